// File: rtl/keymgr_sideload_streamer.sv
// ============================================================================
// Module   : keymgr_sideload_streamer
// Purpose  : Captures a multi-share sideload key on the rising edge of the
//            valid signal and streams it out one 32-bit word at a time.
// Options  : KEYMGR_SIDELOAD_WIPE_EN -- when defined, dropping valid mid-stream
//            or in DONE wipes the held key and aborts the stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keymgr_sideload_streamer #(
    parameter int NumRegsKey   = 8,
    parameter int NumSharesKey = 2
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              key_valid_i,
    input  logic [NumSharesKey*NumRegsKey*32-1:0]             key_sideload_i,
    output logic [31:0]                                       word_o,
    output logic                                              word_valid_o,
    input  logic                                              word_ready_i,
    output logic [((NumSharesKey > 1) ? $clog2(NumSharesKey) : 1)-1:0] share_idx_o,
    output logic [((NumRegsKey > 1) ? $clog2(NumRegsKey) : 1)-1:0]     word_idx_o,
    output logic                                              last_o,
    output logic                                              key_loaded_o
);

    localparam int SHARE_W   = (NumSharesKey > 1) ? $clog2(NumSharesKey) : 1;
    localparam int WORD_W    = (NumRegsKey > 1) ? $clog2(NumRegsKey) : 1;
    localparam int NUM_WORDS = NumSharesKey * NumRegsKey;
    localparam int SEL_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_key [NUM_WORDS];
    logic [SHARE_W-1:0]   r_share_idx;
    logic [WORD_W-1:0]    r_word_idx;
    logic                 r_key_valid_q;
    // Set once valid has been seen low after reset, so a valid that is
    // already high when reset releases never counts as a fresh rise.
    logic                 r_armed;

    logic                 w_rise;
    logic                 w_handshake;
    logic                 w_share_last;
    logic                 w_word_last;
    logic                 w_last_pos;
    logic                 w_wipe;
    logic [SEL_W-1:0]     w_sel;

    assign w_rise       = key_valid_i & ~r_key_valid_q & r_armed;
    assign w_handshake  = (r_state == ST_STREAM) & word_ready_i;
    assign w_share_last = (r_share_idx == SHARE_W'(NumSharesKey - 1));
    assign w_word_last  = (r_word_idx == WORD_W'(NumRegsKey - 1));
    assign w_last_pos   = w_share_last & w_word_last;
    assign w_sel        = SEL_W'(r_share_idx) * SEL_W'(NumRegsKey) + SEL_W'(r_word_idx);

`ifdef KEYMGR_SIDELOAD_WIPE_EN
    assign w_wipe = ~key_valid_i & ((r_state == ST_STREAM) | (r_state == ST_DONE));
`else
    assign w_wipe = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_wipe) begin
                    w_state_next = ST_IDLE;
                end else if (w_handshake && w_last_pos) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!key_valid_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_key_valid_q <= 1'b0;
            r_armed       <= 1'b0;
            r_share_idx   <= '0;
            r_word_idx    <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_key[i] <= '0;
            end
        end else begin
            r_key_valid_q <= key_valid_i;
            if (!key_valid_i) begin
                r_armed <= 1'b1;
            end

            if (w_wipe) begin
                r_share_idx <= '0;
                r_word_idx  <= '0;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    r_key[i] <= '0;
                end
            end else if ((r_state == ST_IDLE) && w_rise) begin
                r_share_idx <= '0;
                r_word_idx  <= '0;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    r_key[i] <= key_sideload_i[i*32 +: 32];
                end
            end else if (w_handshake) begin
                // Indices return to zero after the final word so IDLE/DONE
                // always present (0,0) rather than an out-of-range share.
                if (w_last_pos) begin
                    r_share_idx <= '0;
                    r_word_idx  <= '0;
                end else if (w_word_last) begin
                    r_word_idx  <= '0;
                    r_share_idx <= r_share_idx + SHARE_W'(1);
                end else begin
                    r_word_idx  <= r_word_idx + WORD_W'(1);
                end
            end
        end
    end

    assign word_valid_o = (r_state == ST_STREAM);
    assign word_o       = word_valid_o ? r_key[w_sel] : 32'h0;
    assign share_idx_o  = r_share_idx;
    assign word_idx_o   = r_word_idx;
    assign last_o       = word_valid_o & w_last_pos;
    assign key_loaded_o = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/keymgr_sideload_streamer.md
KEYMGR_SIDELOAD_STREAMER -- requirements
Module: keymgr_sideload_streamer

Interface
REQ-001 SHALL have parameter NumRegsKey, default 8: number of 32-bit words per key share.
REQ-002 SHALL have parameter NumSharesKey, default 2: number of key shares.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port key_valid_i, input, 1: sideload key valid from keymgr.
REQ-006 SHALL have port key_sideload_i, input, NumSharesKey*NumRegsKey*32: flattened key; share s, word i at bits [(s*NumRegsKey+i)*32 +: 32].
REQ-007 SHALL have port word_o, output, 32: streamed key word.
REQ-008 SHALL have port word_valid_o, output, 1: word_o valid.
REQ-009 SHALL have port word_ready_i, input, 1: consumer accepts word.
REQ-010 SHALL have port share_idx_o, output, $clog2(NumSharesKey) (min 1): share index of word_o.
REQ-011 SHALL have port word_idx_o, output, $clog2(NumRegsKey) (min 1): word index of word_o.
REQ-012 SHALL have port last_o, output, 1: word_o is final word of final share.
REQ-013 SHALL have port key_loaded_o, output, 1: full key delivered, held until key_valid_i drops.

Function
REQ-014 SHALL implement FSM states IDLE, STREAM, DONE; reset state IDLE.
REQ-015 SHALL register key_valid_i into key_valid_q; rise = key_valid_i & ~key_valid_q.
REQ-016 IDLE: on rise, SHALL capture key_sideload_i into internal key register, clear both indices, go to STREAM at the same edge.
REQ-017 IDLE with key_valid_i high but no rise (already high at reset release or after DONE) SHALL NOT capture.
REQ-018 STREAM: word_valid_o SHALL be 1, word_o = captured word [share_idx][word_idx]; first word_valid_o one cycle after the rise is sampled.
REQ-019 Ordering SHALL be share-outer, word-inner: (0,0),(0,1)...(0,NumRegsKey-1),(1,0)...
REQ-020 On word_valid_o & word_ready_i, word_idx SHALL increment; at NumRegsKey-1 it wraps to 0 and share_idx increments.
REQ-021 word_o/indices SHALL stay stable while word_valid_o & ~word_ready_i.
REQ-022 last_o SHALL equal word_valid_o & share_idx==NumSharesKey-1 & word_idx==NumRegsKey-1.
REQ-023 Handshake with last_o SHALL move to DONE; word_valid_o 0 in IDLE and DONE.
REQ-024 DONE: key_loaded_o SHALL be 1; on key_valid_i==0 go to IDLE, key_loaded_o 0 next cycle.
REQ-025 key_loaded_o SHALL be 0 in IDLE and STREAM.
REQ-026 Input changes on key_sideload_i after capture SHALL NOT affect streamed words.

Reset
REQ-027 rst_ni low SHALL asynchronously force IDLE, key register to 0, indices to 0, key_valid_q 0.
REQ-028 Reset outputs: word_o 0, word_valid_o 0, share_idx_o 0, word_idx_o 0, last_o 0, key_loaded_o 0.
REQ-029 Reset mid-STREAM SHALL abort with no further words; after release a new rise is required.

Configuration
REQ-030 Macro KEYMGR_SIDELOAD_WIPE_EN defined: key_valid_i low in STREAM or DONE SHALL zero the key register and indices and go to IDLE next edge, word_valid_o 0 from that cycle.
REQ-031 Macro undefined: key_valid_i low in STREAM SHALL NOT abort; stream completes from held copy, then DONE exits to IDLE immediately since key_valid_i low; key register retained.
REQ-032 word_o SHALL be 0 whenever word_valid_o is 0, in both configurations.

Verification
REQ-033 Defaults, key word (s,i)=32'hA000_0000|(s<<8)|i, ready tied 1 -> 16 words in order, 16 consecutive cycles, last_o on 32'hA000_0107, key_loaded_o 1 next cycle.
REQ-034 Ready toggling 1,0,0,1 -> word held stable across stall, no duplicates or skips, total 16 handshakes.
REQ-035 Change key_sideload_i to all-ones after capture -> streamed words unchanged.
REQ-036 WIPE_EN, drop key_valid_i after 5 handshakes -> word_valid_o 0 next cycle, key register 0, no last_o; new rise restarts at (0,0).
REQ-037 WIPE undefined, same stimulus -> remaining 11 words delivered, last_o once, then IDLE.
REQ-038 rst_ni low mid-STREAM asynchronously -> all outputs 0 immediately; key_valid_i held high after release -> no capture until low-then-high.
